// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux.
// Registered one-hot grant, bounded tenure, one dead cycle per handover.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       expired
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic [2:0]       r_last, w_last_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [7:0]       r_gnt, w_gnt_nxt;
  logic             r_exp, w_exp_nxt;

  logic [2:0]       w_win;
  logic             w_own;
  logic             w_others;
  logic             w_full;

  // First set bit scanning circularly from last+1; last itself is checked last.
  function automatic logic [2:0] f_pick(
    input logic [7:0] r,
    input logic [2:0] last
  );
    logic [2:0] idx;
    logic       found;
    f_pick = 3'd0;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && r[idx]) begin
        found  = 1'b1;
        f_pick = idx;
      end
    end
  endfunction

  assign w_win    = f_pick(req, r_last);
  assign w_own    = |(req & r_gnt);
  assign w_others = |(req & ~r_gnt);
  assign w_full   = (r_hold == HOLD_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_exp_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_gnt_nxt   = 8'b1 << w_win;
          w_sel_nxt   = w_win;
          w_hold_nxt  = CNT_W'(1);
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!w_own || (w_full && w_others)) begin
          w_gnt_nxt   = 8'h00;
          w_last_nxt  = r_sel;
          w_hold_nxt  = '0;
          w_state_nxt = IDLE;
          w_exp_nxt   = w_own;
        end else if (!w_full) begin
          w_hold_nxt  = r_hold + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_last  <= 3'd7;
      r_sel   <= 3'd0;
      r_gnt   <= 8'h00;
      r_exp   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign valid   = |r_gnt;
  assign expired = r_exp;

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 bit-select mux among 8 requesters.
- Converts a request vector into a registered one-hot grant and a 3-bit mux select.
- Enforces a maximum grant tenure so that no requester starves the others.
- Sits directly in front of the 8:1 select mux; drives its `sel` input.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one requester may hold the grant while others wait. Legal range is 2..255.
- CNT_W, 8: width of the tenure counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 8: req[i]=1 means requester i wants the mux. Held high for the whole transaction.
- gnt, output, 8: registered one-hot grant; all-zero when idle.
- sel, output, 3: registered mux select; the index of the current or most recent grantee.
- valid, output, 1: high while any grant is active; equals |gnt.
- expired, output, 1: one-cycle pulse on a forced release caused by MAX_HOLD.

Behaviour:
- Reset (sampled rst=1 at an edge):
  - gnt=0, sel=0, valid=0, expired=0.
  - state=IDLE, hold_cnt=0.
  - Priority pointer last=7, so requester 0 has highest priority first.
  - rst overrides everything, including mid-grant: the grant is dropped on that edge with no expired pulse.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, remain in IDLE. Outputs hold: gnt=0, valid=0, sel unchanged.
  - Else pick winner w = the first set bit of req scanning circularly from (last+1) mod 8 upward.
  - On that edge: gnt=1<<w, sel=w, valid=1, hold_cnt=1, state=GRANT.
  - Latency: req sampled at edge N produces gnt visible after edge N.
- GRANT with current grantee c (= sel). Evaluate in priority order each edge:
  1. req[c]==0 (voluntary release):
     - gnt=0, valid=0, last=c, state=IDLE, hold_cnt=0, expired=0.
  2. hold_cnt==MAX_HOLD and (req & ~(1<<c))!=0 (forced release):
     - gnt=0, valid=0, last=c, state=IDLE, hold_cnt=0.
     - expired=1 for exactly this one cycle.
  3. Otherwise keep the grant:
     - hold_cnt = min(hold_cnt+1, MAX_HOLD), saturating.
     - A lone requester therefore keeps the grant indefinitely.
     - It is forcibly released on the first edge where another request is present.
- Every release is followed by exactly one dead cycle (IDLE, gnt=0) before the next grant. This prevents mux glitch overlap between grantees.
- sel holds its last value through IDLE and through reset-free idle periods. It only changes on a grant edge.
- `expired` is 0 in every cycle except the one immediately after a forced release edge.
- Changes on req bits other than c during GRANT have no effect until the next arbitration.
- The pointer updates only on release, never on grant.
- Simultaneous requests: the winner is strictly decided by circular order from last+1.
- Invariants (assert in bench):
  - gnt is one-hot or zero.
  - valid == |gnt.
  - When valid=1, gnt == 1<<sel.

Test Plan:
- Reset then req=8'h01:
  - gnt=8'h01, sel=0, valid=1 one edge after req.
  - Drop req → gnt=0 next edge; last=0.
- After that sequence, req=8'h81:
  - Winner is 7 (scan from 1): sel=7, gnt=8'h80.
  - Release, wait one dead cycle → gnt=8'h01, sel=0.
- req=8'hFF held constant with MAX_HOLD=4:
  - Grants rotate 0,1,2,…,7,0.
  - Each tenure is 4 cycles, followed by an expired pulse and one dead cycle.
  - Period per requester is 5 cycles.
- req=8'h04 held alone for 40 cycles:
  - gnt=8'h04 throughout, expired never asserts, hold_cnt saturates at MAX_HOLD.
  - Then raise req[5] → on the next edge gnt=0, expired=1; the following edge gnt=8'h20, sel=5.
- Mid-grant reset (sel=3, hold_cnt=2):
  - Assert rst for 1 cycle → gnt=0, sel=0, valid=0, expired=0.
  - With req=8'h0C still high after rst drops, the next grant is 2 (pointer back to 7).
- Requester drops req on the same edge hold_cnt reaches MAX_HOLD while others request:
  - Treated as a voluntary release: expired=0, and the next grantee follows circular order.
